// File: rtl/video_timing_control_if.sv
// Signal bundle between the video timing generator and its consumers
// (fetch, scroll-register and NMI logic). The timing generator is the master.
interface video_timing_control_if #(
    parameter int P_count_width = 16
);
    logic                     I_clk_rise;
    logic                     I_render_enable;
    logic                     I_status_read;
    logic                     I_nmi_enable;
    logic [P_count_width-1:0] O_hcount;
    logic [P_count_width-1:0] O_vcount;
    logic                     O_odd_frame;
    logic                     O_not_hblank;
    logic                     O_not_vblank;
    logic                     O_vblank_flag;
    logic                     O_nmi;
    logic [15:0]              O_control;

    modport master (
        input  I_clk_rise, I_render_enable, I_status_read, I_nmi_enable,
        output O_hcount, O_vcount, O_odd_frame, O_not_hblank, O_not_vblank,
               O_vblank_flag, O_nmi, O_control
    );

    modport slave (
        output I_clk_rise, I_render_enable, I_status_read, I_nmi_enable,
        input  O_hcount, O_vcount, O_odd_frame, O_not_hblank, O_not_vblank,
               O_vblank_flag, O_nmi, O_control
    );
endinterface

// File: rtl/video_timing_control.sv
// Video timing control: dot/line counters with frame parity, odd-frame dot
// skip, the decoded 16-bit fetch/scroll control word and the vblank status
// flag with read-race suppression.
module video_timing_control #(
    parameter int P_count_width     = 16,
    parameter int P_dots_per_line   = 341,
    parameter int P_lines_per_frame = 262,
    parameter int P_visible_lines   = 240,
    parameter int P_vblank_line     = 241,
    parameter int P_skip_odd_dot    = 1
) (
    input  logic                  I_vid_clock,
    input  logic                  I_reset,
    video_timing_control_if.master bus
);
    localparam int W = P_count_width;

    localparam logic [W-1:0] C_ONE         = W'(1);
    localparam logic [W-1:0] C_LAST_DOT    = W'(P_dots_per_line - 1);
    localparam logic [W-1:0] C_SKIP_DOT    = W'(P_dots_per_line - 2);
    localparam logic [W-1:0] C_LAST_LINE   = W'(P_lines_per_frame - 1);
    localparam logic [W-1:0] C_VIS_LINES   = W'(P_visible_lines);
    localparam logic [W-1:0] C_VBLANK_LINE = W'(P_vblank_line);
    localparam logic [W-1:0] C_H8          = W'(8);
    localparam logic [W-1:0] C_H256        = W'(256);
    localparam logic [W-1:0] C_H257        = W'(257);
    localparam logic [W-1:0] C_H280        = W'(280);
    localparam logic [W-1:0] C_H304        = W'(304);
    localparam logic [W-1:0] C_H320        = W'(320);

    logic [W-1:0] hcount_q, hcount_d;
    logic [W-1:0] vcount_q, vcount_d;
    logic         odd_frame_q, odd_frame_d;
    logic         vblank_flag_q, vblank_flag_d;

    logic         rendering;
    logic         prerender;
    logic         fetching;
    logic         hzero;
    logic         skip_dot;
    logic [15:0]  control;

    assign hzero     = (hcount_q == '0);
    assign prerender = (vcount_q == C_LAST_LINE);
    assign rendering = (vcount_q < C_VIS_LINES) || prerender;
    assign fetching  = rendering && !hzero;
    assign skip_dot  = (P_skip_odd_dot != 0) && bus.I_render_enable && odd_frame_q &&
                       prerender && (hcount_q == C_SKIP_DOT);

    // Next dot/line position: normal advance, line wrap, frame wrap or odd-frame skip
    always_comb begin
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        odd_frame_d = odd_frame_q;
        if (bus.I_clk_rise) begin
            if (skip_dot) begin
                hcount_d    = '0;
                vcount_d    = '0;
                odd_frame_d = !odd_frame_q;
            end else if (hcount_q == C_LAST_DOT) begin
                hcount_d = '0;
                if (prerender) begin
                    vcount_d    = '0;
                    odd_frame_d = !odd_frame_q;
                end else begin
                    vcount_d = vcount_q + C_ONE;
                end
            end else begin
                hcount_d = hcount_q + C_ONE;
            end
        end
    end

    // Control word decode; strobe bits only fire on a dot-enable clock
    always_comb begin
        control = '0;
        if (fetching) begin
            control[7:0] = 8'd1 << hcount_q[2:0];
        end
        control[8]  = bus.I_clk_rise && hzero && (vcount_q == C_VBLANK_LINE);
        control[9]  = bus.I_clk_rise && hzero && prerender;
        control[10] = rendering;
        control[11] = bus.I_clk_rise && rendering && (hcount_q[2:0] == 3'd0) && !hzero &&
                      !((hcount_q >= C_H257) && (hcount_q <= C_H320));
        control[12] = bus.I_clk_rise && rendering && (hcount_q == C_H256);
        control[13] = bus.I_clk_rise && rendering && (hcount_q == C_H257);
        control[14] = bus.I_clk_rise && prerender &&
                      (hcount_q >= C_H280) && (hcount_q <= C_H304);
        control[15] = !hzero && (hcount_q <= C_H8);
    end

    // Vblank flag: a status read wins over a same-clock set, so the race loses the flag
    always_comb begin
        vblank_flag_d = vblank_flag_q;
        if (bus.I_status_read) begin
            vblank_flag_d = 1'b0;
        end else if (control[8]) begin
            vblank_flag_d = 1'b1;
        end else if (control[9]) begin
            vblank_flag_d = 1'b0;
        end
    end

    // State registers; reset returns to dot 0 of line 0 of an even frame
    always_ff @(posedge I_vid_clock) begin
        if (I_reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            odd_frame_q   <= 1'b0;
            vblank_flag_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            odd_frame_q   <= odd_frame_d;
            vblank_flag_q <= vblank_flag_d;
        end
    end

    assign bus.O_hcount      = hcount_q;
    assign bus.O_vcount      = vcount_q;
    assign bus.O_odd_frame   = odd_frame_q;
    assign bus.O_not_hblank  = !hzero && (hcount_q <= C_H256);
    assign bus.O_not_vblank  = (vcount_q < C_VIS_LINES);
    assign bus.O_vblank_flag = vblank_flag_q;
    assign bus.O_nmi         = vblank_flag_q && bus.I_nmi_enable;
    assign bus.O_control     = control;
endmodule

// File: tb/tb_video_timing_control.sv
// Bench for video_timing_control. Three instances share one clock and inputs:
// a short-frame NTSC-style geometry (dot skip on), a short-frame PAL-style
// geometry (dot skip off) and the default geometry for line decode and reset.
module tb_video_timing_control;
    logic clk;
    logic rst;
    logic rise, rend, rd_cmd, nmi_en;
    int   sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    video_timing_control_if #(.P_count_width(16)) ifn ();
    video_timing_control_if #(.P_count_width(16)) ifp ();
    video_timing_control_if #(.P_count_width(16)) ifd ();

    assign ifn.I_clk_rise = rise;  assign ifn.I_render_enable = rend;
    assign ifn.I_status_read = rd_cmd;  assign ifn.I_nmi_enable = nmi_en;
    assign ifp.I_clk_rise = rise;  assign ifp.I_render_enable = rend;
    assign ifp.I_status_read = rd_cmd;  assign ifp.I_nmi_enable = nmi_en;
    assign ifd.I_clk_rise = rise;  assign ifd.I_render_enable = rend;
    assign ifd.I_status_read = rd_cmd;  assign ifd.I_nmi_enable = nmi_en;

    video_timing_control #(.P_lines_per_frame(20), .P_visible_lines(16),
                           .P_vblank_line(17), .P_skip_odd_dot(1))
        u_ntsc (.I_vid_clock(clk), .I_reset(rst), .bus(ifn.master));
    video_timing_control #(.P_lines_per_frame(24), .P_visible_lines(16),
                           .P_vblank_line(18), .P_skip_odd_dot(0))
        u_pal (.I_vid_clock(clk), .I_reset(rst), .bus(ifp.master));
    video_timing_control u_dflt (.I_vid_clock(clk), .I_reset(rst), .bus(ifd.master));

    // Observation mux: sel picks which instance the checks look at
    int          mon_h, mon_v;
    logic        mon_odd, mon_flag, mon_nmi, mon_nhb, mon_nvb;
    logic [15:0] mon_ctrl;
    always_comb begin
        mon_h = int'(ifd.O_hcount);  mon_v = int'(ifd.O_vcount);
        mon_odd = ifd.O_odd_frame;   mon_flag = ifd.O_vblank_flag;
        mon_nmi = ifd.O_nmi;         mon_ctrl = ifd.O_control;
        mon_nhb = ifd.O_not_hblank;  mon_nvb = ifd.O_not_vblank;
        if (sel == 0) begin
            mon_h = int'(ifn.O_hcount);  mon_v = int'(ifn.O_vcount);
            mon_odd = ifn.O_odd_frame;   mon_flag = ifn.O_vblank_flag;
            mon_nmi = ifn.O_nmi;         mon_ctrl = ifn.O_control;
            mon_nhb = ifn.O_not_hblank;  mon_nvb = ifn.O_not_vblank;
        end else if (sel == 1) begin
            mon_h = int'(ifp.O_hcount);  mon_v = int'(ifp.O_vcount);
            mon_odd = ifp.O_odd_frame;   mon_flag = ifp.O_vblank_flag;
            mon_nmi = ifp.O_nmi;         mon_ctrl = ifp.O_control;
            mon_nhb = ifp.O_not_hblank;  mon_nvb = ifp.O_not_vblank;
        end
    end

    typedef struct {
        string  tag;
        longint val;
    } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input longint obs, input longint expv);
        n_cmp++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic sb_push(input string tag, input longint val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input longint obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", obs, -1);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the selected instance from (0,0) back to (0,0), bounded by a cycle budget.
    // race_mode 1: status read in the set clock; 2: status read at dot 5 of the vblank line.
    task automatic run_frame(input int last_line, input int vbl_line, input int race_mode,
                             output int ticks, output int h340, output int sets,
                             output int vvt_on, output int vvt_off, output int fl_set,
                             output int nmi_set, output int nmi_off, output int fl_clr,
                             output int fl_hi, output int rd_before, output int rd_after);
        bit pend_set, pend_clr, pend_rd;
        ticks = 0; h340 = 0; sets = 0; vvt_on = 0; vvt_off = 0; fl_set = 0; nmi_set = 0;
        nmi_off = 1; fl_clr = 1; fl_hi = 0; rd_before = 0; rd_after = 1;
        pend_set = 0; pend_clr = 0; pend_rd = 0;
        while (ticks < 20000) begin
            rd_cmd = 1'b0;
            if (pend_set) begin
                fl_set = int'(mon_flag);
                nmi_set = int'(mon_nmi);
                nmi_en = 1'b0;
                #1 nmi_off = int'(mon_nmi);
                nmi_en = 1'b1;
                #1 pend_set = 0;
            end
            if (pend_clr) begin fl_clr = int'(mon_flag); pend_clr = 0; end
            if (pend_rd) begin rd_after = int'(mon_flag); pend_rd = 0; end
            if (mon_flag) fl_hi++;
            if (mon_v == last_line && mon_h == 340) h340++;
            if (mon_ctrl[14]) begin
                if (mon_v == last_line) vvt_on++;
                else vvt_off++;
            end
            if (mon_ctrl[8]) begin
                sets++;
                pend_set = 1;
                if (race_mode == 1) rd_cmd = 1'b1;
            end
            if (mon_ctrl[9]) pend_clr = 1;
            if (race_mode == 2 && mon_v == vbl_line && mon_h == 5) begin
                rd_before = int'(mon_flag);
                rd_cmd = 1'b1;
                pend_rd = 1;
            end
            step();
            ticks++;
            if (mon_h == 0 && mon_v == 0) break;
        end
        rd_cmd = 1'b0;
    endtask

    int t, h3, st, von, voff, fs, ns, noff, fc, fh, rb, ra;
    int odd_prev, odd_tog;
    int f1_cnt, f1_bad, hv_cnt, hv_bad, hv_late, lm_cnt, lm_first, iv_pos, he_pos;
    int stall_h, guard, pre_h, pre_v;
    logic [15:0] stall_strb;
    bit stall_done;

    initial begin
        sel = 2; rst = 1'b1; rise = 1'b1; rend = 1'b0; rd_cmd = 1'b1; nmi_en = 1'b1;

        // ---- reset state (default geometry), reset overriding dot enable and read
        sb_push("rst_h", 0); sb_push("rst_v", 0); sb_push("rst_odd", 0);
        sb_push("rst_flag", 0); sb_push("rst_ctrl", 16'h0400);
        sb_push("rst_nhb", 0); sb_push("rst_nvb", 1);
        step(); step();
        sb_pop(mon_h); sb_pop(mon_v); sb_pop(mon_odd); sb_pop(mon_flag);
        sb_pop(mon_ctrl); sb_pop(mon_nhb); sb_pop(mon_nvb);
        rd_cmd = 1'b0;
        step();
        rst = 1'b0;

        // ---- short NTSC frame, rendering off: full length, one set, flag/NMI, clear
        sel = 0;
        sb_push("ntsc_off_len", 6820); sb_push("ntsc_off_sets", 1);
        sb_push("flag_after_set", 1); sb_push("nmi_after_set", 1);
        sb_push("nmi_gated_off", 0); sb_push("flag_after_clr", 0);
        sb_push("odd_toggles", 1); sb_push("odd_after", 1);
        odd_prev = int'(mon_odd);
        run_frame(19, 17, 0, t, h3, st, von, voff, fs, ns, noff, fc, fh, rb, ra);
        odd_tog = (int'(mon_odd) != odd_prev) ? 1 : 0;
        sb_pop(t); sb_pop(st); sb_pop(fs); sb_pop(ns); sb_pop(noff); sb_pop(fc);
        sb_pop(odd_tog); sb_pop(mon_odd);

        // ---- rendering on: odd frame skips dot 340 of pre-render line, read race
        rend = 1'b1;
        sb_push("odd_len", 6819); sb_push("odd_h340", 0); sb_push("race_flag_hi", 0);
        sb_push("odd_vvt", 25);
        run_frame(19, 17, 1, t, h3, st, von, voff, fs, ns, noff, fc, fh, rb, ra);
        sb_pop(t); sb_pop(h3); sb_pop(fh); sb_pop(von);

        // ---- even frame: full length, read at dot 5 of vblank line clears the flag
        sb_push("even_len", 6820); sb_push("even_h340", 1);
        sb_push("rd5_before", 1); sb_push("rd5_after", 0);
        run_frame(19, 17, 2, t, h3, st, von, voff, fs, ns, noff, fc, fh, rb, ra);
        sb_pop(t); sb_pop(h3); sb_pop(rb); sb_pop(ra);

        // ---- short PAL frames, no dot skip: equal lengths, vert_v_eq_t on last line only
        sel = 1; rst = 1'b1; step(); rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            sb_push("pal_len", 8184); sb_push("pal_h340", 1);
            sb_push("pal_vvt_on", 25); sb_push("pal_vvt_off", 0);
            run_frame(23, 18, 0, t, h3, st, von, voff, fs, ns, noff, fc, fh, rb, ra);
            sb_pop(t); sb_pop(h3); sb_pop(von); sb_pop(voff);
        end

        // ---- default geometry: scan line 0 with one stalled dot at 256
        sel = 2; rst = 1'b1; step(); rst = 1'b0;
        f1_cnt = 0; f1_bad = 0; hv_cnt = 0; hv_bad = 0; hv_late = 0;
        lm_cnt = 0; lm_first = -1; iv_pos = -1; he_pos = -1;
        stall_done = 0; stall_h = -1; stall_strb = 16'hFFFF; guard = 0;
        sb_push("f1_cnt", 43); sb_push("f1_bad", 0); sb_push("hv_cnt", 34);
        sb_push("hv_bad", 0); sb_push("hv_late", 2); sb_push("iv_pos", 256);
        sb_push("he_pos", 257); sb_push("lm_cnt", 8); sb_push("lm_first", 1);
        sb_push("stall_strobes", 0); sb_push("stall_hold", 256);
        while (mon_v == 0 && guard < 400) begin
            if (mon_h == 256 && !stall_done) begin
                rise = 1'b0;
                #1 stall_strb = mon_ctrl & 16'h7B00;
                step();
                stall_h = mon_h;
                rise = 1'b1;
                #1 stall_done = 1;
            end
            if (mon_ctrl[1]) begin
                f1_cnt++;
                if (mon_h % 8 != 1) f1_bad++;
            end
            if (mon_ctrl[11]) begin
                hv_cnt++;
                if (mon_h % 8 != 0 || mon_h == 0) hv_bad++;
                if (mon_h > 320) hv_late++;
            end
            if (mon_ctrl[12]) iv_pos = mon_h;
            if (mon_ctrl[13]) he_pos = mon_h;
            if (mon_ctrl[15]) begin
                lm_cnt++;
                if (lm_first < 0) lm_first = mon_h;
            end
            step();
            guard++;
        end
        sb_pop(f1_cnt); sb_pop(f1_bad); sb_pop(hv_cnt); sb_pop(hv_bad); sb_pop(hv_late);
        sb_pop(iv_pos); sb_pop(he_pos); sb_pop(lm_cnt); sb_pop(lm_first);
        sb_pop(stall_strb); sb_pop(stall_h);

        // ---- mid-frame reset at (100,50)
        sb_push("pre_h", 100); sb_push("pre_v", 50);
        sb_push("post_rst_h", 0); sb_push("post_rst_v", 0); sb_push("post_rst_ctrl", 16'h0400);
        guard = 0;
        while (!(mon_v == 50 && mon_h == 100) && guard < 20000) begin
            step();
            guard++;
        end
        pre_h = mon_h; pre_v = mon_v;
        sb_pop(pre_h); sb_pop(pre_v);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_pop(mon_h); sb_pop(mon_v); sb_pop(mon_ctrl);

        check_val("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
